adc_frame_align: RTL and testbench
==================================

# adc_frame_align

Frame-alignment controller for the ADC LVDS deserializer, running in the `adc_clk` (divclk) domain. It watches the deserialized frame-clock word `frmData` and issues single-cycle `bitslip` pulses to the deserializer until `frmData` equals the expected frame pattern. It then qualifies sample data with `aligned` and continuously monitors lock, re-aligning automatically on loss. It is enabled by the MicroBlaze GPIO bit that drives `adc_en`.

## Interface
- `FRAME_PATTERN`, 8'hF0: expected `frmData` word when aligned.
- `SETTLE_CYC`, 4: cycles waited after enable or after each bitslip before checking; must be ≥2.
- `CHECK_CYC`, 16: consecutive matches required to declare lock.
- `MAX_SLIPS`, 8: bitslips allowed per alignment attempt before failure.
- `MISS_LIMIT`, 4: consecutive mismatches in LOCKED that trigger re-alignment.
- `adc_clk`, in, 1: deserializer divided clock; the only clock.
- `adc_rst`, in, 1: synchronous, active-high reset.
- `adc_en`, in, 1: alignment enable (level).
- `frmData`, in, 8: deserialized frame word.
- `bitslip`, out, 1: one-cycle bitslip pulse to the deserializer.
- `aligned`, out, 1: frame locked; downstream qualifies adc1/2/4/8 with this.
- `align_err`, out, 1: alignment failed after `MAX_SLIPS`.
- `slip_count`, out, $clog2(MAX_SLIPS+1): bitslips issued in the current attempt.
- `relock_count`, out, 8: saturating count of lock losses since enable.
- `state`, out, 3: current FSM state, for ILA/status.

## Operation
- States: IDLE, WAIT, CHECK, SLIP, LOCKED, FAIL.
- IDLE: all counters cleared. `adc_en`=1 → WAIT, with the settle counter loaded.
- WAIT: count `SETTLE_CYC` cycles → CHECK, with the match counter cleared.
- CHECK: each cycle, compare `frmData` against `FRAME_PATTERN`.
  - Match: increment the match counter. The `CHECK_CYC`-th consecutive match → LOCKED.
  - Mismatch with `slip_count` < `MAX_SLIPS` → SLIP.
  - Mismatch with `slip_count` = `MAX_SLIPS` → FAIL.
- SLIP: exactly one cycle. `bitslip`=1, `slip_count`++, then → WAIT.
- LOCKED: the miss counter counts consecutive mismatches; any match clears it.
  - On reaching `MISS_LIMIT`: → WAIT, with `slip_count` and miss counter cleared, and `relock_count`++ (saturating at 255).
- FAIL: `align_err`=1. Holds until `adc_en`=0.
- `adc_en`=0 in any state → IDLE on the next edge. `slip_count`, `relock_count` and `align_err` clear. A fresh attempt requires `adc_en` to deassert and reassert; there is no auto-retry from FAIL.
- The IDLE and FAIL transitions caused by `adc_en`=0 take priority over all other transitions.

## Timing
- All outputs are registered and update on the same edge as `state`.
  - `aligned` is 1 iff state is LOCKED.
  - `bitslip` is 1 iff state is SLIP.
- Reset values: state IDLE, `bitslip` 0, `aligned` 0, `align_err` 0, `slip_count` 0, `relock_count` 0. Reset mid-operation behaves identically, including mid-SLIP: the pulse is cut and does not repeat.
- `frmData` is sampled combinationally in CHECK/LOCKED on the same edge as the state update.
- Bitslip pulses are spaced at least `SETTLE_CYC`+2 cycles apart, which meets the ISERDES minimum spacing.
- Lock latency, measured from the first edge sampling `adc_en`=1, for N slips each caught on the first CHECK cycle: 1 + N·(SETTLE_CYC+2) + SETTLE_CYC + CHECK_CYC edges.
  - Defaults: 21 + 6N.
- Loss-of-lock: `aligned` falls on the edge that samples the `MISS_LIMIT`-th consecutive mismatch.
- Boundary: the `MAX_SLIPS`-th slip is still issued; only a mismatch after it goes to FAIL. With defaults, at most 8 pulses are issued per attempt.

## Structure
- Shared package `adc_pkg` holds:
  - the `align_state_t` enum (IDLE=0, WAIT=1, CHECK=2, SLIP=3, LOCKED=4, FAIL=5), so ILA decode and firmware status agree;
  - `ADC_FRAME_PATTERN_DEFAULT` = 8'hF0.
- Single module, with no sub-module. The settle, match and miss counters share one down-counter register, loaded per state.
- Instantiated between `adc` (`frmData` in, `bitslip` out) and the MicroBlaze GPIO (`adc_en` in, status out via a CDC synchronizer outside this block).

## Test plan
- `frmData`=8'hF0 constant, `adc_en` raised at cycle 0 → no `bitslip`; `aligned`=1 at edge 21; `slip_count`=0.
- The deserializer model needs 3 slips before producing 8'hF0 → exactly 3 `bitslip` pulses, each 6 cycles apart; `aligned` at edge 39; `slip_count`=3.
- `frmData` never matches → 8 pulses, then `align_err`=1 and state FAIL; it holds. Dropping `adc_en` returns to IDLE next edge with all status cleared.
- In LOCKED, inject 3 bad words, 1 good, then 4 bad → no relock after the first 3; `aligned` falls on the 4th consecutive bad word; `relock_count`=1; relock succeeds.
- Assert `adc_rst` during SLIP and during LOCKED → next edge: state IDLE, all outputs at reset values; `bitslip` is not re-pulsed.
- Deassert `adc_en` during CHECK, then reassert → a clean restart; lock latency again equals 21+6N.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared definitions for the ADC frame-alignment path.
// State encodings are fixed so ILA decode and firmware status agree.
package adc_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT   = 3'd1,
        CHECK  = 3'd2,
        SLIP   = 3'd3,
        LOCKED = 3'd4,
        FAIL   = 3'd5
    } align_state_t;

    localparam logic [7:0] ADC_FRAME_PATTERN_DEFAULT = 8'hF0;

endpackage

// File: rtl/adc_frame_align.sv
// Frame-alignment controller: bitslips the deserializer until frmData matches
// the frame pattern, then monitors lock and re-aligns on sustained loss.
module adc_frame_align
    import adc_pkg::*;
#(
    parameter logic [7:0]  FRAME_PATTERN = ADC_FRAME_PATTERN_DEFAULT,
    parameter int unsigned SETTLE_CYC    = 4,
    parameter int unsigned CHECK_CYC     = 16,
    parameter int unsigned MAX_SLIPS     = 8,
    parameter int unsigned MISS_LIMIT    = 4
) (
    input  logic                           adc_clk,
    input  logic                           adc_rst,
    input  logic                           adc_en,
    input  logic [7:0]                     frmData,
    output logic                           bitslip,
    output logic                           aligned,
    output logic                           align_err,
    output logic [$clog2(MAX_SLIPS+1)-1:0] slip_count,
    output logic [7:0]                     relock_count,
    output logic [2:0]                     state
);

    localparam int unsigned SLIP_W  = $clog2(MAX_SLIPS + 1);
    localparam int unsigned CNT_MAX0 = (SETTLE_CYC > CHECK_CYC) ? SETTLE_CYC : CHECK_CYC;
    localparam int unsigned CNT_MAX  = (CNT_MAX0 > MISS_LIMIT) ? CNT_MAX0 : MISS_LIMIT;
    localparam int unsigned CNT_W    = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

    // The counter is loaded with N-1 and the state advances when it reads zero,
    // so each phase lasts exactly N edges.
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CHECK_LD  = CNT_W'(CHECK_CYC - 1);
    localparam logic [CNT_W-1:0] MISS_LD   = CNT_W'(MISS_LIMIT - 1);

    align_state_t      r_state, w_state;
    logic [CNT_W-1:0]  r_cnt, w_cnt;
    logic [SLIP_W-1:0] r_slip_cnt, w_slip_cnt;
    logic [7:0]        r_relock, w_relock;
    logic              r_bitslip, r_aligned, r_align_err;
    logic              w_match;

    assign w_match = (frmData == FRAME_PATTERN);

    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_slip_cnt = r_slip_cnt;
        w_relock   = r_relock;
        if (!adc_en) begin
            w_state    = IDLE;
            w_cnt      = '0;
            w_slip_cnt = '0;
            w_relock   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state    = WAIT;
                    w_cnt      = SETTLE_LD;
                    w_slip_cnt = '0;
                    w_relock   = '0;
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        w_state = CHECK;
                        w_cnt   = CHECK_LD;
                    end else begin
                        w_cnt = r_cnt - CNT_W'(1);
                    end
                end
                CHECK: begin
                    if (w_match) begin
                        if (r_cnt == '0) begin
                            w_state = LOCKED;
                            w_cnt   = MISS_LD;
                        end else begin
                            w_cnt = r_cnt - CNT_W'(1);
                        end
                    end else if (r_slip_cnt < SLIP_W'(MAX_SLIPS)) begin
                        w_state    = SLIP;
                        w_slip_cnt = r_slip_cnt + SLIP_W'(1);
                    end else begin
                        w_state = FAIL;
                    end
                end
                SLIP: begin
                    w_state = WAIT;
                    w_cnt   = SETTLE_LD;
                end
                LOCKED: begin
                    if (w_match) begin
                        w_cnt = MISS_LD;
                    end else if (r_cnt == '0) begin
                        w_state    = WAIT;
                        w_cnt      = SETTLE_LD;
                        w_slip_cnt = '0;
                        if (r_relock != 8'hFF) begin
                            w_relock = r_relock + 8'd1;
                        end
                    end else begin
                        w_cnt = r_cnt - CNT_W'(1);
                    end
                end
                FAIL: begin
                    w_state = FAIL;
                end
                default: begin
                    w_state = IDLE;
                end
            endcase
        end
    end

    // Status flags are decoded from the next state so they change on the same
    // edge as the state register.
    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_slip_cnt  <= '0;
            r_relock    <= '0;
            r_bitslip   <= 1'b0;
            r_aligned   <= 1'b0;
            r_align_err <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_slip_cnt  <= w_slip_cnt;
            r_relock    <= w_relock;
            r_bitslip   <= (w_state == SLIP);
            r_aligned   <= (w_state == LOCKED);
            r_align_err <= (w_state == FAIL);
        end
    end

    assign bitslip      = r_bitslip;
    assign aligned      = r_aligned;
    assign align_err    = r_align_err;
    assign slip_count   = r_slip_cnt;
    assign relock_count = r_relock;
    assign state        = r_state;

endmodule

// File: tb/tb_adc_frame_align.sv
// Directed bench for adc_frame_align with a simple bitslip-counting
// deserializer model and hand-computed latencies.
module tb_adc_frame_align;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [7:0] frm;
    logic       bitslip, aligned, align_err;
    logic [3:0] slip_count;
    logic [7:0] relock_count;
    logic [2:0] state;

    int n_cmp = 0;
    int n_err = 0;

    int pulses = 0;
    int ncyc   = 0;
    int stamps[$];

    int base      = 0;
    int need      = 0;
    bit force_bad = 1'b0;

    always #5 clk = ~clk;

    adc_frame_align dut (
        .adc_clk      (clk),
        .adc_rst      (rst),
        .adc_en       (en),
        .frmData      (frm),
        .bitslip      (bitslip),
        .aligned      (aligned),
        .align_err    (align_err),
        .slip_count   (slip_count),
        .relock_count (relock_count),
        .state        (state)
    );

    // Deserializer model: the right word appears once enough slips were seen.
    always_comb begin
        if (force_bad)
            frm = 8'h00;
        else if ((pulses - base) >= need)
            frm = 8'hF0;
        else
            frm = 8'h78;
    end

    always @(negedge clk) begin
        ncyc = ncyc + 1;
        if (bitslip) begin
            pulses = pulses + 1;
            stamps.push_back(ncyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_aligned(input int budget, output int n);
        n = 0;
        while (!aligned && n < budget) begin
            step();
            n++;
        end
    endtask

    task automatic wait_err(input int budget, output int n);
        n = 0;
        while (!align_err && n < budget) begin
            step();
            n++;
        end
    endtask

    task automatic wait_slip(input int budget, output int n);
        n = 0;
        while (!bitslip && n < budget) begin
            step();
            n++;
        end
    endtask

    task automatic disable_idle();
        en = 1'b0;
        steps(2);
    endtask

    initial begin
        int n, p, qb;

        // Reset values
        steps(2);
        chk("rst_state", state, 0);
        chk("rst_bitslip", bitslip, 0);
        chk("rst_aligned", aligned, 0);
        chk("rst_align_err", align_err, 0);
        chk("rst_slip_count", slip_count, 0);
        chk("rst_relock", relock_count, 0);
        rst = 1'b0;
        step();

        // Clean frame word: lock with no slips
        need = 0; base = pulses; en = 1'b1;
        wait_aligned(100, n);
        chk("t1_latency", n, 21);
        chk("t1_pulses", pulses - base, 0);
        chk("t1_slip_count", slip_count, 0);
        chk("t1_state", state, 4);

        // Lock monitoring: 3 bad, 1 good, 4 bad
        force_bad = 1'b1; steps(3);
        chk("t4_after3bad", aligned, 1);
        force_bad = 1'b0; step();
        force_bad = 1'b1; steps(3);
        chk("t4_after3more", aligned, 1);
        chk("t4_relock_hold", relock_count, 0);
        step();
        chk("t4_fall", aligned, 0);
        chk("t4_state_wait", state, 1);
        chk("t4_relock", relock_count, 1);
        force_bad = 1'b0;
        wait_aligned(100, n);
        chk("t4_relock_latency", n, 20);
        chk("t4_relock_keep", relock_count, 1);

        // Reset while locked
        rst = 1'b1; step();
        chk("t5_lk_state", state, 0);
        chk("t5_lk_aligned", aligned, 0);
        chk("t5_lk_relock", relock_count, 0);
        chk("t5_lk_bitslip", bitslip, 0);
        rst = 1'b0;
        disable_idle();

        // Three slips needed
        need = 3; base = pulses; qb = stamps.size(); en = 1'b1;
        wait_aligned(200, n);
        chk("t2_latency", n, 39);
        chk("t2_pulses", pulses - base, 3);
        chk("t2_slip_count", slip_count, 3);
        if (stamps.size() >= qb + 3) begin
            chk("t2_gap1", stamps[qb+1] - stamps[qb], 6);
            chk("t2_gap2", stamps[qb+2] - stamps[qb+1], 6);
        end else begin
            chk("t2_stamps", stamps.size() - qb, 3);
        end
        disable_idle();

        // Never matches: 8 slips then FAIL
        need = 99; base = pulses; qb = stamps.size(); en = 1'b1;
        wait_err(300, n);
        chk("t3_err_latency", n, 54);
        chk("t3_pulses", pulses - base, 8);
        chk("t3_state", state, 5);
        chk("t3_slip_count", slip_count, 8);
        if (stamps.size() >= qb + 8) begin
            for (int i = 1; i < 8; i++)
                chk($sformatf("t3_gap%0d", i), stamps[qb+i] - stamps[qb+i-1], 6);
        end else begin
            chk("t3_stamps", stamps.size() - qb, 8);
        end
        steps(20);
        chk("t3_hold_state", state, 5);
        chk("t3_hold_err", align_err, 1);
        chk("t3_hold_pulses", pulses - base, 8);
        en = 1'b0; step();
        chk("t3_idle_state", state, 0);
        chk("t3_idle_err", align_err, 0);
        chk("t3_idle_slip", slip_count, 0);
        step();

        // Reset during SLIP: pulse cut, not repeated
        need = 99; base = pulses; en = 1'b1;
        wait_slip(50, n);
        chk("t5_slip_edge", n, 6);
        chk("t5_slip_seen", bitslip, 1);
        rst = 1'b1; step();
        chk("t5_sl_state", state, 0);
        chk("t5_sl_bitslip", bitslip, 0);
        chk("t5_sl_slip_count", slip_count, 0);
        p = pulses;
        step();
        chk("t5_sl_bitslip2", bitslip, 0);
        chk("t5_sl_norepeat", pulses, p);
        chk("t5_sl_pulses", pulses - base, 1);
        rst = 1'b0;
        disable_idle();

        // Drop enable during CHECK, then restart
        need = 1; base = pulses; en = 1'b1;
        steps(5);
        chk("t6_in_check", state, 2);
        en = 1'b0; step();
        chk("t6_idle", state, 0);
        base = pulses; en = 1'b1;
        wait_aligned(200, n);
        chk("t6_latency", n, 27);
        chk("t6_pulses", pulses - base, 1);
        chk("t6_slip_count", slip_count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
